// File: rtl/audio_rx.sv
// I2S-style microphone receiver: generates bclk/ws and captures the left-channel word.
// Optional AUDIO_RX_SYNC_EN adds a two-flop synchroniser on d_in.
module audio_rx #(
    parameter int unsigned DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        d_in,
    output logic        bclk,
    output logic        ws,
    output logic [15:0] d_out,
    output logic        done,
    output logic        act
);

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   d_out_q, d_out_d;
    logic               bclk_q, bclk_d;
    logic               ws_q, ws_d;
    logic               done_q, done_d;
    logic               sample_bit;
    logic               tick;
    logic [BIT_W-1:0]   bit_nxt;

`ifdef AUDIO_RX_SYNC_EN
    logic [1:0] sync_q, sync_d;

    assign sync_d     = {sync_q[0], d_in};
    assign sample_bit = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end
`else
    assign sample_bit = d_in;
`endif

    // Next-state: divider, slot counter, capture and frame-end handling
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        d_out_d   = d_out_q;
        bclk_d    = bclk_q;
        ws_d      = ws_q;
        done_d    = 1'b0;
        tick      = (div_cnt_q == DIV_W'(DIV - 1));
        bit_nxt   = bit_cnt_q + BIT_W'(1);

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                shift_d   = '0;
                bclk_d    = 1'b0;
                ws_d      = 1'b0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
                if (tick) begin
                    bclk_d = !bclk_q;
                end
                // Rise event: slots 1..16 carry the left word, slot 0 is the I2S delay
                if (tick && !bclk_q && (bit_cnt_q != '0) && (bit_cnt_q <= BIT_W'(WIDTH))) begin
                    shift_d = {shift_q[WIDTH-2:0], sample_bit};
                    if (bit_cnt_q == BIT_W'(WIDTH)) begin
                        d_out_d = {shift_q[WIDTH-2:0], sample_bit};
                        done_d  = 1'b1;
                    end
                end
                // Fall event: advance slot, ws tracks the upper half of the frame
                if (tick && bclk_q) begin
                    bit_cnt_d = bit_nxt;
                    ws_d      = bit_nxt[BIT_W-1];
                    if ((bit_nxt == '0) && !enable) begin
                        state_d = IDLE;
                        bclk_d  = 1'b0;
                        ws_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            d_out_q   <= '0;
            bclk_q    <= 1'b0;
            ws_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            d_out_q   <= d_out_d;
            bclk_q    <= bclk_d;
            ws_q      <= ws_d;
            done_q    <= done_d;
        end
    end

    assign bclk  = bclk_q;
    assign ws    = ws_q;
    assign d_out = d_out_q;
    assign done  = done_q;
    assign act   = (state_q == RUN);

endmodule

// File: tb/tb_audio_rx.sv
// Directed bench for audio_rx at DIV=4: per-frame vector table plus enable-drop and reset-abort sequences.
module tb_audio_rx;

    localparam int unsigned DIV   = 4;
    localparam int          FRAME = 64 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        d_in;
    logic        bclk;
    logic        ws;
    logic [15:0] d_out;
    logic        done;
    logic        act;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] word;
        logic        fill;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [5];

    audio_rx #(.DIV(DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .d_in   (d_in),
        .bclk   (bclk),
        .ws     (ws),
        .d_out  (d_out),
        .done   (done),
        .act    (act)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Called #1 after edge t of a frame; returns #1 after edge t+FRAME (or right after an abort).
    task automatic run_frame(input logic [15:0] w, input logic fill, input logic [15:0] exp,
                             input int drop_j, input int abort_j);
        int slot;
        for (int j = 0; j < FRAME; j++) begin
            slot = j / (2 * DIV);
            d_in = (slot >= 1 && slot <= 16) ? w[16 - slot] : fill;
            if (j == drop_j) enable = 1'b0;
            if (j == abort_j) begin
                reset = 1'b0;
                #1;
                chk("abort_bclk",  {31'd0, bclk}, 32'd0);
                chk("abort_ws",    {31'd0, ws},   32'd0);
                chk("abort_dout",  {16'd0, d_out}, 32'd0);
                chk("abort_done",  {31'd0, done}, 32'd0);
                chk("abort_act",   {31'd0, act},  32'd0);
                return;
            end
            chk("bclk", {31'd0, bclk}, {31'd0, ((j / DIV) % 2) == 1});
            chk("ws",   {31'd0, ws},   {31'd0, slot >= 16});
            chk("act",  {31'd0, act},  32'd1);
            chk("done", {31'd0, done}, {31'd0, j == 33 * DIV});
            if (j == 33 * DIV) chk("d_out", {16'd0, d_out}, {16'd0, exp});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vecs[0] = '{word: 16'hB4C0, fill: 1'b0, exp: 16'hB4C0};
        vecs[1] = '{word: 16'h8001, fill: 1'b0, exp: 16'h8001};
        vecs[2] = '{word: 16'h7FFE, fill: 1'b0, exp: 16'h7FFE};
        vecs[3] = '{word: 16'h0000, fill: 1'b1, exp: 16'h0000};
        vecs[4] = '{word: 16'h5A5A, fill: 1'b1, exp: 16'h5A5A};

        reset  = 1'b0;
        enable = 1'b0;
        d_in   = 1'b0;
        #1;
        chk("rst_bclk", {31'd0, bclk}, 32'd0);
        chk("rst_ws",   {31'd0, ws},   32'd0);
        chk("rst_dout", {16'd0, d_out}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_act",  {31'd0, act},  32'd0);

        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_act", {31'd0, act}, 32'd0);

        // Back-to-back frames with enable held high
        enable = 1'b1;
        @(posedge clk);
        #1;
        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].word, vecs[v].fill, vecs[v].exp, -1, -1);
        end

        // Enable dropped in slot 5: frame completes, then IDLE at edge t+FRAME
        run_frame(16'h1234, 1'b0, 16'h1234, 5 * 2 * DIV, -1);
        chk("drop_act",  {31'd0, act},  32'd0);
        chk("drop_bclk", {31'd0, bclk}, 32'd0);
        chk("drop_ws",   {31'd0, ws},   32'd0);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("idle_done", {31'd0, done}, 32'd0);
            chk("idle_hold", {16'd0, d_out}, 32'h1234);
        end

        // Restart from slot 0, then abort the following frame in slot 10
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        run_frame(16'hC3A5, 1'b0, 16'hC3A5, -1, -1);
        run_frame(16'hFFFF, 1'b0, 16'hFFFF, -1, 10 * 2 * DIV + 3);

        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            chk("post_rst_done", {31'd0, done}, 32'd0);
            chk("post_rst_act",  {31'd0, act},  32'd0);
        end
        chk("post_rst_dout", {16'd0, d_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_rx.md
# audio_rx

Serial PCM audio receiver for the microphone path of the PCM audio subsystem. It is the receive-side counterpart of the serial audio transmitter. It generates the bit clock (`bclk`) and word select (`ws`) for an I2S-style MEMS microphone. It deserialises the left-channel 16-bit sample from `d_in` and presents it in parallel on `d_out` with a one-cycle `done` strobe, for the downstream sample buffer or DSP stage.

## Interface
- `DIV`, default 4: system clocks per bclk half-period. Legal range is 2..255, or 3..255 when `AUDIO_RX_SYNC_EN` is defined.
- `WIDTH`, fixed at 16: sample width. The frame is 2×WIDTH bclk slots.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  run request, level sensitive
- `d_in`  in  1  serial data from the microphone; changes on bclk falling edge, MSB first
- `bclk`  out  1  bit clock to the microphone, clk/(2·DIV)
- `ws`  out  1  word select: 0 = left half-frame, 1 = right half-frame
- `d_out`  out  16  last captured left sample, two's complement
- `done`  out  1  one-clk strobe; `d_out` is updated on the same edge
- `act`  out  1  high while in RUN

## Operation
- States:
  - IDLE: `bclk`=0, `ws`=0, counters cleared.
  - RUN: generating clocks and capturing.
- IDLE→RUN on the first clk edge with `enable`=1. `div_cnt`, `bit_cnt` and the shift register are cleared.
- `div_cnt` counts 0..DIV-1. On the edge where it equals DIV-1, `bclk` toggles and `div_cnt` wraps to 0.
- bclk rise event: the edge where `bclk` goes 0→1. On that edge the data bit is sampled.
- bclk fall event: the edge where `bclk` goes 1→0. On that edge `bit_cnt` advances, wrapping 0..31 → 0.
- `ws` is registered on fall events: 1 when the new `bit_cnt` is 16..31, else 0.
- Slot k is the bclk period with `bit_cnt`=k.
  - Slot 0 is the I2S one-bit delay and is ignored.
  - Slots 1..16 carry data bits 15..0. The shift register shifts left, inserting at the LSB.
  - Slots 17..31 (right channel) are ignored.
- On the rise event of slot 16, `d_out` is loaded with the completed word and `done` is registered high for exactly one clk.
- `enable` falling in RUN: the current frame runs to completion, including its `done`. On the slot-31 fall event (`bit_cnt` wraps to 0) the FSM returns to IDLE with `bclk`=0 and `ws`=0. If `enable` is high at that edge, RUN continues seamlessly.
- `d_out` holds its value between `done` strobes and while in IDLE.

## Timing
- Reset values: `bclk`=0, `ws`=0, `d_out`=0, `done`=0, `act`=0; all internal counters and state are 0/IDLE.
- Reset asserted mid-frame aborts immediately and asynchronously. No `done` is produced for the partial frame.
- Let edge t be the edge that enters RUN (`act`=1 after t).
  - Slot k rise occurs at edge t+DIV+2k·DIV.
  - Slot k fall occurs at edge t+2(k+1)·DIV.
- First `done` is high during the cycle after edge t+33·DIV. Subsequent `done` strobes are every 64·DIV clks.
- `act` falls after the slot-31 fall edge, t+64·DIV, of the final frame.
- Capture latency from the LSB sample edge to `done`/`d_out` is 0 cycles, since both are registered on the same edge.

## Configuration
- `AUDIO_RX_SYNC_EN`
  - Defined: `d_in` passes through a two-flop synchroniser. Each rise event samples the synchronised value, which reflects `d_in` 2 clks earlier. DIV ≥ 3 is required so the sample still lies inside the slot.
  - Undefined: `d_in` is sampled directly on the rise-event edge. All other timing is identical.

## Test plan
- Reset pulse low during slot 10 of a running frame → all outputs 0 immediately, no `done`, and IDLE after release.
- DIV=4, `enable`=1, `d_in` driving 16'hB4C0 MSB-first in slots 1..16 → `done` one cycle after edge t+132, `d_out`=16'hB4C0, `act`=1.
- Back-to-back frames 16'h8001 then 16'h7FFE → two `done` pulses 256 clks apart, with `d_out` showing each value in turn.
- `d_in`=1 throughout slots 0 and 17..31, data 16'h0000 in slots 1..16 → `d_out`=16'h0000, proving slot masking.
- `enable` dropped at slot 5 → `done` still occurs with the correct word, then `act`=0, `bclk`=0 and `ws`=0 after edge t+256. Re-asserting `enable` restarts at slot 0.
- With `AUDIO_RX_SYNC_EN` and DIV=4, repeat the 16'hB4C0 case → identical `d_out` and `done` timing.
